instr_loader: RTL

Boot-time program loader for the RISC-V core: receives a length-prefixed byte stream over a valid/ready interface, packs bytes little-endian into 32-bit words and writes them into instruction memory starting at address 0. It holds the CPU in reset for the whole load and releases it when the image is complete. It is the hardware writer of the same `test.bin` image format the CPU bench loads into instruction memory.

---
 rtl/instr_loader_pkg.sv | 15 +
 rtl/instr_loader_if.sv | 21 ++
 rtl/instr_loader_byte_packer.sv | 37 +++
 rtl/instr_loader.sv | 110 +++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared loader definitions: FSM state encoding and stream framing constants.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        ST_HEADER  = 3'd0,
        ST_PAYLOAD = 3'd1,
        ST_WRITE   = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } loader_state_e;

    localparam int unsigned HEADER_BYTES = 4;
    localparam int unsigned WORD_BYTES   = 4;

endpackage

// File: rtl/instr_loader_if.sv
// Byte stream input and instruction-memory write port of the loader.
// Handshake: a byte moves on a rising clock edge where byte_valid && byte_ready;
// the source holds byte_data steady while byte_valid is high and not yet accepted.
interface instr_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_write_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_write_enable, mem_addr, mem_write_data
    );

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_write_enable, mem_addr, mem_write_data
    );
endinterface

// File: rtl/instr_loader_byte_packer.sv
// Gathers four stream bytes little-endian into a 32-bit word; shared by the
// length header and the payload words.
module instr_loader_byte_packer
    import instr_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_complete_o
);

    logic [1:0]  lane_q;
    logic [31:0] word_q;
    logic [31:0] word_d;

    // New bytes enter at the top, so the first byte ends up in bits [7:0].
    assign word_d          = {byte_i, word_q[31:8]};
    assign word_o          = word_d;
    assign word_complete_o = shift_i && (lane_q == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q <= 2'd0;
            word_q <= 32'd0;
        end else if (clear_i) begin
            lane_q <= 2'd0;
            word_q <= 32'd0;
        end else if (shift_i) begin
            lane_q <= lane_q + 2'd1;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: length-prefixed byte stream -> 32-bit instruction memory writes,
// holding the CPU in reset until the whole image has been written.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic          clock,
    input  logic          reset,
    instr_loader_if.slave bus,
    input  logic          reload,
    output logic          cpu_reset,
    output logic          done,
    output logic          error,
    output loader_state_e state_o
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    loader_state_e state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   remaining_q, remaining_d;
    logic [31:0]   wdata_q, wdata_d;

    logic        accepting;
    logic        xfer;
    logic        restart;
    logic [31:0] packed_word;
    logic        word_complete;

    assign accepting = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD);
    assign xfer      = bus.byte_valid && accepting;
    assign restart   = (state_q == ST_DONE) && reload;

    instr_loader_byte_packer u_packer (
        .clk_i           (clock),
        .rst_ni          (reset),
        .clear_i         (restart),
        .shift_i         (xfer),
        .byte_i          (bus.byte_data),
        .word_o          (packed_word),
        .word_complete_o (word_complete)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_HEADER;
            addr_q      <= 32'd0;
            remaining_q <= 32'd0;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            wdata_q     <= wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        wdata_d     = wdata_q;
        case (state_q)
            ST_HEADER: begin
                if (word_complete) begin
                    // Only whole words that fit in memory are loadable.
                    if ((packed_word == 32'd0) || (packed_word[1:0] != 2'd0) ||
                        (packed_word > MEM_LIMIT)) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d     = ST_PAYLOAD;
                        addr_d      = 32'd0;
                        remaining_d = packed_word;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (word_complete) begin
                    wdata_d = packed_word;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_d      = addr_q + 32'd4;
                remaining_d = remaining_q - 32'd4;
                state_d     = (remaining_q == 32'd4) ? ST_DONE : ST_PAYLOAD;
            end
            ST_DONE: begin
                if (reload) begin
                    state_d     = ST_HEADER;
                    addr_d      = 32'd0;
                    remaining_d = 32'd0;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_HEADER;
        endcase
    end

    assign bus.byte_ready       = accepting;
    assign bus.mem_write_enable = (state_q == ST_WRITE);
    assign bus.mem_addr         = addr_q;
    assign bus.mem_write_data   = wdata_q;
    assign cpu_reset            = (state_q != ST_DONE);
    assign done                 = (state_q == ST_DONE);
    assign error                = (state_q == ST_ERROR);
    assign state_o              = state_q;

endmodule
